// File: rtl/ysyx_24080014_pkg.sv
// Shared encodings for the ysyx_24080014 execute sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_24080014_pkg;

  // Operand-mux select codes shared by rs1_ctr and rs2_ctr
  typedef logic [2:0] sel_t;
  localparam sel_t SEL_PC     = 3'b000;
  localparam sel_t SEL_PC_ADD = 3'b001;
  localparam sel_t SEL_RS_OUT = 3'b010;
  localparam sel_t SEL_IMM    = 3'b011;
  localparam sel_t SEL_ZERO   = 3'b100;

  // Decoded instruction class delivered by the IDU; values above OP_SYSTEM are illegal
  typedef enum logic [3:0] {
    OP_ALU_R  = 4'd0,
    OP_ALU_I  = 4'd1,
    OP_LUI    = 4'd2,
    OP_AUIPC  = 4'd3,
    OP_JAL    = 4'd4,
    OP_JALR   = 4'd5,
    OP_BRANCH = 4'd6,
    OP_LOAD   = 4'd7,
    OP_STORE  = 4'd8,
    OP_SYSTEM = 4'd9
  } op_class_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EX1,
    ST_EX2,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE    = 2'b00,
    HC_EBREAK  = 2'b01,
    HC_ILLEGAL = 2'b10,
    HC_TIMEOUT = 2'b11
  } halt_code_e;

  // True for any class the sequencer knows how to execute (SYSTEM included)
  function automatic logic is_known_class(input op_class_e c);
    return c <= OP_SYSTEM;
  endfunction

endpackage

// File: rtl/ysyx_24080014_exu_seq_if.sv
// Bundle of IDU handshake, datapath controls, LSU handshake and status for the sequencer.
// Latency: n/a (wires only).
// Backpressure: inst_ready / lsu_req_ready carry the valid-ready handshakes.
interface ysyx_24080014_exu_seq_if #(
  parameter int CNT_W = 32
);
  import ysyx_24080014_pkg::*;

  logic             inst_valid;
  logic             inst_ready;
  logic [3:0]       op_class;
  logic             br_taken;
  sel_t             rs1_ctr;
  sel_t             rs2_ctr;
  logic             tgt_we;
  logic             lsu_req_valid;
  logic             lsu_we;
  logic             lsu_req_ready;
  logic             lsu_resp_valid;
  logic             rf_we;
  logic             rf_src;
  logic             pc_we;
  logic             pc_src;
  logic [CNT_W-1:0] instret;
  logic             halt;
  logic [1:0]       halt_code;

  // Sequencer side
  modport master (
    input  inst_valid, op_class, br_taken, lsu_req_ready, lsu_resp_valid,
    output inst_ready, rs1_ctr, rs2_ctr, tgt_we, lsu_req_valid, lsu_we,
           rf_we, rf_src, pc_we, pc_src, instret, halt, halt_code
  );

  // IDU / datapath / LSU side
  modport slave (
    output inst_valid, op_class, br_taken, lsu_req_ready, lsu_resp_valid,
    input  inst_ready, rs1_ctr, rs2_ctr, tgt_we, lsu_req_valid, lsu_we,
           rf_we, rf_src, pc_we, pc_src, instret, halt, halt_code
  );

endinterface

// File: rtl/ysyx_24080014_exu_timer.sv
// MEM_WAIT watchdog: counts cycles while enabled, flags the last allowed cycle.
// Latency: expired is combinational from the count; clear takes effect next cycle.
// Backpressure: none; saturates at LIMIT-1 until cleared.
module ysyx_24080014_exu_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  // expired marks the LIMIT-th enabled cycle, so the owner leaves after exactly LIMIT cycles
  assign expired = (cnt == W'(LIMIT - 1));

  // Count enabled cycles since the last clear, holding at the expiry value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_24080014_exu_seq.sv
// Multi-cycle execute sequencer: walks one instruction class through EX/MEM/WB and retires it.
// Latency: 3 cycles ALU/untaken branch, 4 jumps/taken branch, 5+waits load/store.
// Backpressure: inst_ready only in FETCH; MEM_REQ holds until lsu_req_ready; halts on LSU timeout.
module ysyx_24080014_exu_seq
  import ysyx_24080014_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_24080014_exu_seq_if.master     bus
);

  state_e           state, state_nxt;
  op_class_e        class_q;
  logic             br_q;
  halt_code_e       hc_q, hc_nxt;
  logic [CNT_W-1:0] instret_q;
  logic             tmo_expired;

  sel_t rs1_ctr, rs2_ctr;
  logic inst_ready, tgt_we, lsu_req_valid, lsu_we;
  logic rf_we, rf_src, pc_we, pc_src;

  // Watchdog runs only in MEM_WAIT and restarts from zero on every entry
  ysyx_24080014_exu_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_MEM_WAIT),
    .en      (state == ST_MEM_WAIT),
    .expired (tmo_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // Instruction context: class on accept, branch outcome in EX1, halt reason, retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_q   <= OP_ALU_R;
      br_q      <= 1'b0;
      hc_q      <= HC_NONE;
      instret_q <= '0;
    end else begin
      if (state == ST_FETCH && bus.inst_valid) class_q <= op_class_e'(bus.op_class);
      if (state == ST_EX1 && class_q == OP_BRANCH) br_q <= bus.br_taken;
      hc_q <= hc_nxt;
      if (state == ST_WB) instret_q <= instret_q + 1'b1;
    end
  end

  // Next state and halt reason
  always_comb begin
    state_nxt = state;
    hc_nxt    = hc_q;
    case (state)
      ST_FETCH:  if (bus.inst_valid) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (class_q == OP_SYSTEM) begin
          state_nxt = ST_HALT;
          hc_nxt    = HC_EBREAK;
        end else if (!is_known_class(class_q)) begin
          state_nxt = ST_HALT;
          hc_nxt    = HC_ILLEGAL;
        end else begin
          state_nxt = ST_EX1;
        end
      end
      ST_EX1: begin
        case (class_q)
          OP_JAL, OP_JALR:     state_nxt = ST_EX2;
          OP_BRANCH:           state_nxt = bus.br_taken ? ST_EX2 : ST_WB;
          OP_LOAD, OP_STORE:   state_nxt = ST_MEM_REQ;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_EX2:     state_nxt = ST_WB;
      ST_MEM_REQ: if (bus.lsu_req_ready) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        // A response on the final watchdog cycle still completes the access
        if (bus.lsu_resp_valid) begin
          state_nxt = ST_WB;
        end else if (tmo_expired) begin
          state_nxt = ST_HALT;
          hc_nxt    = HC_TIMEOUT;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Moore output decode from state, latched class and latched branch flag
  always_comb begin
    rs1_ctr       = SEL_ZERO;
    rs2_ctr       = SEL_ZERO;
    inst_ready    = 1'b0;
    tgt_we        = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_we        = 1'b0;
    rf_we         = 1'b0;
    rf_src        = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 1'b0;
    case (state)
      ST_FETCH: inst_ready = 1'b1;
      ST_EX1: begin
        case (class_q)
          OP_ALU_R:  begin rs1_ctr = SEL_RS_OUT; rs2_ctr = SEL_RS_OUT; end
          OP_ALU_I:  begin rs1_ctr = SEL_RS_OUT; rs2_ctr = SEL_IMM;    end
          OP_LUI:    begin rs1_ctr = SEL_ZERO;   rs2_ctr = SEL_IMM;    end
          OP_AUIPC:  begin rs1_ctr = SEL_PC;     rs2_ctr = SEL_IMM;    end
          OP_JAL:    begin rs1_ctr = SEL_PC;     rs2_ctr = SEL_IMM;    tgt_we = 1'b1; end
          OP_JALR:   begin rs1_ctr = SEL_RS_OUT; rs2_ctr = SEL_IMM;    tgt_we = 1'b1; end
          OP_BRANCH: begin rs1_ctr = SEL_RS_OUT; rs2_ctr = SEL_RS_OUT; end
          OP_LOAD, OP_STORE: begin rs1_ctr = SEL_RS_OUT; rs2_ctr = SEL_IMM; end
          default: ;
        endcase
      end
      ST_EX2: begin
        // Taken branch computes its target here; jumps compute the link value PC+4
        if (class_q == OP_BRANCH) begin
          rs1_ctr = SEL_PC;
          rs2_ctr = SEL_IMM;
          tgt_we  = 1'b1;
        end else begin
          rs1_ctr = SEL_PC_ADD;
          rs2_ctr = SEL_ZERO;
        end
      end
      ST_MEM_REQ: begin
        rs1_ctr       = SEL_RS_OUT;
        rs2_ctr       = SEL_IMM;
        lsu_req_valid = 1'b1;
        lsu_we        = (class_q == OP_STORE);
      end
      ST_MEM_WAIT: begin
        rs1_ctr = SEL_RS_OUT;
        rs2_ctr = SEL_IMM;
      end
      ST_WB: begin
        pc_we  = 1'b1;
        pc_src = (class_q == OP_JAL) || (class_q == OP_JALR) ||
                 ((class_q == OP_BRANCH) && br_q);
        rf_we  = !((class_q == OP_BRANCH) || (class_q == OP_STORE));
        rf_src = (class_q == OP_LOAD);
      end
      default: ;
    endcase
  end

  assign bus.inst_ready    = inst_ready;
  assign bus.rs1_ctr       = rs1_ctr;
  assign bus.rs2_ctr       = rs2_ctr;
  assign bus.tgt_we        = tgt_we;
  assign bus.lsu_req_valid = lsu_req_valid;
  assign bus.lsu_we        = lsu_we;
  assign bus.rf_we         = rf_we;
  assign bus.rf_src        = rf_src;
  assign bus.pc_we         = pc_we;
  assign bus.pc_src        = pc_src;
  assign bus.instret       = instret_q;
  assign bus.halt          = (state == ST_HALT);
  assign bus.halt_code     = hc_q;

endmodule

// File: tb/tb_ysyx_24080014_exu_seq.sv
// Directed bench for the execute sequencer, watchdog shortened to 4 cycles.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: LSU ready/response driven by hand per scenario.
module tb_ysyx_24080014_exu_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ysyx_24080014_exu_seq_if #(.CNT_W(32)) bus();

  ysyx_24080014_exu_seq #(
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {inst_ready, tgt_we, lsu_req_valid, lsu_we, rf_we, rf_src, pc_we, pc_src, halt}
  function automatic logic [8:0] strb();
    return {bus.inst_ready, bus.tgt_we, bus.lsu_req_valid, bus.lsu_we,
            bus.rf_we, bus.rf_src, bus.pc_we, bus.pc_src, bus.halt};
  endfunction

  function automatic logic [5:0] sels();
    return {bus.rs1_ctr, bus.rs2_ctr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one class in FETCH; returns sampled in DECODE
  task automatic issue(input logic [3:0] cls);
    bus.inst_valid = 1'b1;
    bus.op_class   = cls;
    step();
    bus.inst_valid = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [5:0] s, input logic [8:0] st);
    check({tag, "_sel"}, 32'(sels()), 32'(s));
    check({tag, "_strb"}, 32'(strb()), 32'(st));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_state(tag, 6'b100_100, 9'b100000000);
    check({tag, "_instret"}, bus.instret, 32'd0);
    check({tag, "_hcode"}, 32'(bus.halt_code), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.inst_valid     = 1'b0;
    bus.op_class       = 4'd0;
    bus.br_taken       = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    chk_reset_vals("idle");

    // ALU_I: DECODE, EX1 RS/IMM, WB rf_we+pc_we, FETCH with instret 1
    issue(4'd1);
    chk_state("alui_dec", 6'b100_100, 9'b000000000);
    step();
    chk_state("alui_ex1", 6'b010_011, 9'b000000000);
    step();
    chk_state("alui_wb", 6'b100_100, 9'b000010100);
    check("alui_wb_instret", bus.instret, 32'd0);
    step();
    chk_state("alui_fetch", 6'b100_100, 9'b100000000);
    check("alui_instret", bus.instret, 32'd1);

    // JAL: EX1 PC/IMM + tgt_we, EX2 PC_ADD/ZERO, WB pc_src=1
    issue(4'd4);
    step();
    chk_state("jal_ex1", 6'b000_011, 9'b010000000);
    step();
    chk_state("jal_ex2", 6'b001_100, 9'b000000000);
    step();
    chk_state("jal_wb", 6'b100_100, 9'b000010110);
    step();
    check("jal_instret", bus.instret, 32'd2);
    check("jal_fetch_rdy", 32'(bus.inst_ready), 32'd1);

    // BRANCH not taken: EX1 RS/RS then WB with pc_src=0, rf_we=0
    issue(4'd6);
    bus.br_taken = 1'b0;
    step();
    chk_state("bnt_ex1", 6'b010_010, 9'b000000000);
    step();
    chk_state("bnt_wb", 6'b100_100, 9'b000000100);
    step();
    check("bnt_instret", bus.instret, 32'd3);

    // BRANCH taken: flag dropped after EX1 must not matter in WB
    issue(4'd6);
    bus.br_taken = 1'b1;
    step();
    chk_state("bt_ex1", 6'b010_010, 9'b000000000);
    step();
    bus.br_taken = 1'b0;
    chk_state("bt_ex2", 6'b000_011, 9'b010000000);
    step();
    chk_state("bt_wb", 6'b100_100, 9'b000000110);
    step();
    check("bt_instret", bus.instret, 32'd4);

    // LOAD: request stalled 3 cycles, early response ignored, response 2 cycles into MEM_WAIT
    issue(4'd7);
    step();
    chk_state("ld_ex1", 6'b010_011, 9'b000000000);
    step();
    for (int i = 0; i < 4; i++) begin
      chk_state($sformatf("ld_req%0d", i), 6'b010_011, 9'b001000000);
      if (i == 3) begin
        bus.lsu_req_ready  = 1'b1;
        bus.lsu_resp_valid = 1'b1;
      end
      step();
    end
    bus.lsu_req_ready  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    chk_state("ld_wait0", 6'b010_011, 9'b000000000);
    step();
    chk_state("ld_wait1", 6'b010_011, 9'b000000000);
    bus.lsu_resp_valid = 1'b1;
    step();
    bus.lsu_resp_valid = 1'b0;
    chk_state("ld_wb", 6'b100_100, 9'b000011100);
    step();
    check("ld_instret", bus.instret, 32'd5);

    // ALU_R aborted by reset in EX1: no strobes, instret back to 0
    issue(4'd0);
    step();
    chk_state("alur_ex1", 6'b010_010, 9'b000000000);
    pulse_rst();
    chk_reset_vals("alur_abort");

    // STORE with no response: 4 MEM_WAIT cycles then timeout halt, no pc_we
    issue(4'd8);
    bus.lsu_req_ready = 1'b1;
    step();
    step();
    chk_state("st_req", 6'b010_011, 9'b001100000);
    step();
    bus.lsu_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_state($sformatf("st_wait%0d", i), 6'b010_011, 9'b000000000);
      step();
    end
    chk_state("st_halt", 6'b100_100, 9'b000000001);
    check("st_hcode", 32'(bus.halt_code), 32'd3);
    bus.inst_valid = 1'b1;
    step();
    bus.inst_valid = 1'b0;
    chk_state("st_halt_hold", 6'b100_100, 9'b000000001);
    check("st_hcode_hold", 32'(bus.halt_code), 32'd3);
    check("st_instret", bus.instret, 32'd0);
    pulse_rst();

    // SYSTEM halts with ebreak code straight from DECODE
    issue(4'd9);
    step();
    chk_state("sys_halt", 6'b100_100, 9'b000000001);
    check("sys_hcode", 32'(bus.halt_code), 32'd1);
    pulse_rst();

    // Class 15 is illegal
    issue(4'd15);
    step();
    chk_state("ill_halt", 6'b100_100, 9'b000000001);
    check("ill_hcode", 32'(bus.halt_code), 32'd2);
    pulse_rst();
    chk_reset_vals("ill_cleared");

    // LUI after recovery: EX1 ZERO/IMM, retires normally
    issue(4'd2);
    step();
    chk_state("lui_ex1", 6'b100_011, 9'b000000000);
    step();
    chk_state("lui_wb", 6'b100_100, 9'b000010100);
    step();
    check("lui_instret", bus.instret, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24080014_exu_seq.md
# ysyx_24080014_exu_seq

Multi-cycle execute sequencer for the ysyx_24080014 NPC. It accepts one decoded instruction class per handshake from the IFU/IDU. It then steps the ALU operand muxes through one or two ALU passes, sequences the LSU request/response, and issues the register-file and PC write strobes. It also counts retired instructions and halts on ebreak, on an illegal class, or on an LSU timeout.

## Interface
- `MEM_TIMEOUT`, 255: maximum number of cycles spent in MEM_WAIT before halting.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `inst_valid` in 1: IDU offers a decoded instruction.
- `inst_ready` out 1: sequencer accepts it.
- `op_class` in 4: instruction class. Sampled on the handshake.
- `br_taken` in 1: ALU compare result, valid in EX1 of BRANCH.
- `rs1_ctr` out 3: operand-A select. Encoding: 000 PC, 001 PC+4, 010 RS, 011 IMM, 100 ZERO.
- `rs2_ctr` out 3: operand-B select, same encoding as `rs1_ctr`.
- `tgt_we` out 1: latch the ALU result into the target register.
- `lsu_req_valid` out 1: LSU request valid.
- `lsu_we` out 1: request is a store.
- `lsu_req_ready` in 1: LSU accepts the request.
- `lsu_resp_valid` in 1: LSU response (load data or store ack).
- `rf_we` out 1: register-file write.
- `rf_src` out 1: write-back source. 0 ALU, 1 LSU data.
- `pc_we` out 1: PC write.
- `pc_src` out 1: PC source. 0 PC+4, 1 latched target.
- `instret` out CNT_W: retired-instruction count.
- `halt` out 1: sequencer stopped.
- `halt_code` out 2: stop reason. 00 none, 01 ebreak, 10 illegal, 11 timeout.

## Operation
- States: FETCH, DECODE, EX1, EX2, MEM_REQ, MEM_WAIT, WB, HALT. Reset state is FETCH.
- FETCH: `inst_ready`=1. On `inst_valid`&`inst_ready`, latch `op_class` and go to DECODE.
- DECODE: one cycle for operands to settle. Unknown classes and SYSTEM go to HALT. All other classes go to EX1.
- Operand selects, rs1/rs2, per class:
  - ALU_R in EX1: RS/RS.
  - ALU_I in EX1: RS/IMM.
  - LUI in EX1: ZERO/IMM.
  - AUIPC in EX1: PC/IMM.
  - JAL: EX1 PC/IMM with `tgt_we`=1, then EX2 PC_ADD/ZERO.
  - JALR: EX1 RS/IMM with `tgt_we`=1, then EX2 PC_ADD/ZERO.
  - BRANCH: EX1 RS/RS. If `br_taken`, go to EX2 with PC/IMM and `tgt_we`=1. Otherwise go to WB.
  - LOAD/STORE: EX1 RS/IMM, then MEM_REQ. The RS/IMM selects are held through MEM_REQ and MEM_WAIT.
- Selects in FETCH, DECODE, WB and HALT are ZERO/ZERO.
- MEM_REQ: `lsu_req_valid`=1, and `lsu_we`=1 for STORE. Both are held until `lsu_req_ready`, then go to MEM_WAIT.
- MEM_WAIT: on `lsu_resp_valid`, go to WB. A timeout counter is cleared on entry and increments each cycle. When it reaches MEM_TIMEOUT without a response, go to HALT with code 11.
- WB: single cycle. `pc_we`=1 for every class, and `instret` increments.
  - `pc_src`=1 for JAL, JALR and taken BRANCH.
  - `rf_we`=1 for ALU_R, ALU_I, LUI, AUIPC, JAL, JALR and LOAD. It is 0 for BRANCH and STORE.
  - `rf_src`=1 only for LOAD.
  - Next state is FETCH.
- HALT: absorbing until reset. `halt`=1, `halt_code` holds its value, `inst_ready`=0, and all strobes are 0.
- The taken/not-taken decision is registered in EX1 and used in WB.
- `instret` wraps modulo 2^CNT_W.

## Timing
- All outputs are Moore-decoded from the state register, the latched class and the latched branch flag. There is no combinational input-to-output path.
- Reset values:
  - state FETCH, `inst_ready`=1.
  - `rs1_ctr`=`rs2_ctr`=100.
  - `tgt_we`, `lsu_req_valid`, `lsu_we`, `rf_we`, `rf_src`, `pc_we`, `pc_src` all 0.
  - `instret`=0, `halt`=0, `halt_code`=00.
- Cycles from the accepting FETCH edge to the FETCH re-entry edge:
  - ALU/LUI/AUIPC: 3 (DECODE, EX1, WB).
  - Untaken BRANCH: 3.
  - JAL/JALR and taken BRANCH: 4.
  - LOAD/STORE: 5 + request wait + response wait.
- `lsu_resp_valid` arriving in the same cycle the request is accepted is ignored. The response is only sampled in MEM_WAIT.
- `inst_valid` is ignored outside FETCH.
- Asserting `rst` mid-instruction aborts immediately: no write strobes, `instret` cleared.

## Structure
- Package `ysyx_24080014_pkg` holds:
  - the operand-select codes (PC, PC_ADD, RS_OUT, IMM, ZERO);
  - the op_class enum: ALU_R=0, ALU_I=1, LUI=2, AUIPC=3, JAL=4, JALR=5, BRANCH=6, LOAD=7, STORE=8, SYSTEM=9;
  - the state enum;
  - the halt codes.
- One sub-module: `ysyx_24080014_exu_timer`, the MEM_WAIT timeout counter with clear/enable/expired.

## Test plan
- ALU_I handshake: EX1 shows 010/011, WB has `rf_we`=1, `pc_src`=0, `instret` 0→1, FETCH re-entered 3 cycles later.
- JAL: EX1 shows 000/011 with `tgt_we`=1, EX2 shows 001/100, WB has `rf_we`=1 and `pc_src`=1.
- BRANCH: `br_taken`=0 gives WB after EX1 with `pc_src`=0. `br_taken`=1 goes through EX2 (000/011) and gives `pc_src`=1. Both have `rf_we`=0.
- LOAD with `lsu_req_ready` low for 3 cycles and response 2 cycles later: `lsu_req_valid` held for 4 cycles, WB has `rf_src`=1.
- STORE with no response and MEM_TIMEOUT=4: `halt`=1 and `halt_code`=11 after 4 MEM_WAIT cycles, no `pc_we` pulse.
- SYSTEM class gives `halt_code`=01, class 15 gives 10. Pulsing `rst` in EX1 gives FETCH with all outputs at their reset values.
